arc4_phase_ctrl: RTL and testbench
==================================

// Module: arc4_phase_ctrl
// PURPOSE
//  Top-level sequencer for the ARC4 datapath: on one start request it runs init (S[i]=i), then KSA, then PRGA,
//  each via the rdy/en handshake, and arbitrates the single-port 256x8 S memory so only the active phase drives it.
//  Sits between the board wrapper (start/status) and the init/ksa/prga cores plus s_mem.
// PARAMETERS
//  TIMEOUT   4096  max cycles per phase in ARM+WAIT before declaring error; 0 disables watchdog
//  RUN_PRGA  1     1: run init->ksa->prga; 0: stop after ksa
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst          in   1  synchronous, active-high reset
//  en           in   1  start request; accepted only in a cycle where rdy=1
//  rdy          out  1  1 = idle, ready to accept en
//  err          out  1  sticky watchdog error; cleared only by rst
//  phase        out  2  0 idle/err, 1 init, 2 ksa, 3 prga
//  init_en      out  1  one-cycle start pulse to init core
//  init_rdy     in   1  init core ready/done
//  ksa_en       out  1  one-cycle start pulse to ksa core
//  ksa_rdy      in   1  ksa core ready/done
//  prga_en      out  1  one-cycle start pulse to prga core
//  prga_rdy     in   1  prga core ready/done
//  init_addr/init_wrdata/init_wren  in 8/8/1  init core S-mem request
//  ksa_addr/ksa_wrdata/ksa_wren     in 8/8/1  ksa core S-mem request
//  prga_addr/prga_wrdata/prga_wren  in 8/8/1  prga core S-mem request
//  s_addr       out  8  muxed S-mem address
//  s_wrdata     out  8  muxed S-mem write data
//  s_wren       out  1  muxed S-mem write enable
// BEHAVIOUR
//  - States: IDLE, ARM_x, PULSE_x, WAIT_x (x = INIT, KSA, PRGA), ERR. Moore outputs decoded from registered state.
//  - Reset (rst=1 at an edge): state=IDLE, timer=0, busy_seen=0 next cycle; rdy=1, err=0, phase=0, all *_en=0,
//    s_addr=0, s_wrdata=0, s_wren=0. Applies mid-run: no further *_en pulses after reset.
//  - IDLE: rdy=1. en=1 -> ARM_INIT. en while rdy=0 is ignored (not queued).
//  - ARM_x: wait for x_rdy=1, then -> PULSE_x. PULSE_x: x_en=1 for exactly one cycle, -> WAIT_x, busy_seen cleared.
//  - WAIT_x: busy_seen set when x_rdy=0; phase complete when busy_seen=1 and x_rdy=1 (a core that has not yet
//    dropped rdy after en is never treated as done). INIT done -> ARM_KSA; KSA done -> ARM_PRGA if RUN_PRGA
//    else IDLE; PRGA done -> IDLE.
//  - Latency: en at edge k -> ARM_INIT in cycle k+1; if init_rdy=1, init_en high in cycle k+2. Done detected at
//    edge j -> next ARM in j+1; rdy returns 1 the cycle after the final phase completes.
//  - Watchdog: timer cleared on entry to every ARM_x and every WAIT_x; increments each cycle in ARM/WAIT; if it
//    reaches TIMEOUT with state unchanged -> ERR. ERR: err=1, rdy=0, phase=0, *_en=0, s_wren=0; exits only on rst.
//    TIMEOUT=0: timer never triggers.
//  - Arbitration: phase owns S memory in its ARM, PULSE and WAIT states; s_* = owner's addr/wrdata/wren
//    (combinational mux). Non-owner requests are dropped entirely. IDLE/ERR: s_addr=0, s_wrdata=0, s_wren=0.
//  - No sub-core ever receives more than one en per start request.
// TESTING
//  1 rst=1 two cycles -> rdy=1, err=0, phase=0, all *_en=0, s_wren=0.
//  2 Models: init busy 256, ksa 768, prga 64 cycles; pulse en -> init_en high exactly 2 cycles later, one pulse
//    each of init_en/ksa_en/prga_en in order, rdy=1 again after prga_rdy returns; phase walks 1,2,3,0.
//  3 During ksa phase init model drives wren=1 addr=8'h55 data=8'hAA -> s_wren/s_addr/s_wrdata track ksa only.
//  4 Core keeps rdy=1 for 3 cycles after en before dropping -> controller stays in WAIT, no early advance.
//  5 TIMEOUT=16, ksa model never re-asserts rdy -> err=1 exactly 16 cycles into WAIT_KSA, rdy=0, s_wren=0;
//    en ignored; rst -> err=0, rdy=1.
//  6 rst asserted mid-KSA -> IDLE next cycle, no prga_en; RUN_PRGA=0 run -> no prga_en, rdy=1 after ksa.

Source files
------------

// File: rtl/arc4_phase_ctrl.sv
// ARC4 phase sequencer: runs init -> ksa -> prga on one start request
// and arbitrates the single-port S memory between the three cores.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   en / rdy       start request / idle indication
//   err            sticky watchdog error, cleared only by rst
//   phase          0 idle/err, 1 init, 2 ksa, 3 prga
//   <x>_en/<x>_rdy start pulse / ready-done handshake per core
//   <x>_addr/_wrdata/_wren  S-mem request from each core
//   s_addr/s_wrdata/s_wren  muxed S-mem port
module arc4_phase_ctrl #(
   parameter int TIMEOUT  = 4096,
   parameter bit RUN_PRGA = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       rdy,
   output logic       err,
   output logic [1:0] phase,
   output logic       init_en,
   input  logic       init_rdy,
   output logic       ksa_en,
   input  logic       ksa_rdy,
   output logic       prga_en,
   input  logic       prga_rdy,
   input  logic [7:0] init_addr,
   input  logic [7:0] init_wrdata,
   input  logic       init_wren,
   input  logic [7:0] ksa_addr,
   input  logic [7:0] ksa_wrdata,
   input  logic       ksa_wren,
   input  logic [7:0] prga_addr,
   input  logic [7:0] prga_wrdata,
   input  logic       prga_wren,
   output logic [7:0] s_addr,
   output logic [7:0] s_wrdata,
   output logic       s_wren
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ARM_INIT,
      S_PULSE_INIT,
      S_WAIT_INIT,
      S_ARM_KSA,
      S_PULSE_KSA,
      S_WAIT_KSA,
      S_ARM_PRGA,
      S_PULSE_PRGA,
      S_WAIT_PRGA,
      S_ERR
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [TW-1:0]   timer_q;
   logic [TW-1:0]   timer_d;
   logic            busy_q;
   logic            busy_d;
   logic            tmo;

   // Per-phase view of the active core, shared by all ARM/WAIT states
   logic            cur_rdy;
   state_t          pulse_s;
   state_t          wait_s;
   state_t          done_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         busy_q  <= busy_d;
      end
   end

   // Phase decode: owner of S memory, active core, Moore outputs
   always_comb begin
      rdy      = 1'b0;
      err      = 1'b0;
      phase    = 2'd0;
      init_en  = 1'b0;
      ksa_en   = 1'b0;
      prga_en  = 1'b0;
      s_addr   = 8'h00;
      s_wrdata = 8'h00;
      s_wren   = 1'b0;
      cur_rdy  = 1'b0;
      pulse_s  = S_IDLE;
      wait_s   = S_IDLE;
      done_s   = S_IDLE;
      unique case (state_q)
         S_IDLE: rdy = 1'b1;
         S_ARM_INIT, S_PULSE_INIT, S_WAIT_INIT: begin
            phase    = 2'd1;
            init_en  = (state_q == S_PULSE_INIT);
            s_addr   = init_addr;
            s_wrdata = init_wrdata;
            s_wren   = init_wren;
            cur_rdy  = init_rdy;
            pulse_s  = S_PULSE_INIT;
            wait_s   = S_WAIT_INIT;
            done_s   = S_ARM_KSA;
         end
         S_ARM_KSA, S_PULSE_KSA, S_WAIT_KSA: begin
            phase    = 2'd2;
            ksa_en   = (state_q == S_PULSE_KSA);
            s_addr   = ksa_addr;
            s_wrdata = ksa_wrdata;
            s_wren   = ksa_wren;
            cur_rdy  = ksa_rdy;
            pulse_s  = S_PULSE_KSA;
            wait_s   = S_WAIT_KSA;
            done_s   = RUN_PRGA ? S_ARM_PRGA : S_IDLE;
         end
         S_ARM_PRGA, S_PULSE_PRGA, S_WAIT_PRGA: begin
            phase    = 2'd3;
            prga_en  = (state_q == S_PULSE_PRGA);
            s_addr   = prga_addr;
            s_wrdata = prga_wrdata;
            s_wren   = prga_wren;
            cur_rdy  = prga_rdy;
            pulse_s  = S_PULSE_PRGA;
            wait_s   = S_WAIT_PRGA;
            done_s   = S_IDLE;
         end
         S_ERR: err = 1'b1;
         default: ;
      endcase
   end

   // Next state. Timer defaults to zero so every state change
   // (including entry to ARM and WAIT) restarts the watchdog.
   always_comb begin
      state_d = state_q;
      timer_d = '0;
      busy_d  = busy_q;
      tmo     = (TIMEOUT != 0) && (timer_q == T_LAST);
      unique case (state_q)
         S_IDLE: begin
            if (en) state_d = S_ARM_INIT;
         end
         S_ARM_INIT, S_ARM_KSA, S_ARM_PRGA: begin
            if (cur_rdy)  state_d = pulse_s;
            else if (tmo) state_d = S_ERR;
            else          timer_d = timer_q + 1'b1;
         end
         S_PULSE_INIT, S_PULSE_KSA, S_PULSE_PRGA: begin
            state_d = wait_s;
            busy_d  = 1'b0;
         end
         S_WAIT_INIT, S_WAIT_KSA, S_WAIT_PRGA: begin
            // A core still showing rdy right after en has
            // not started yet; only rdy after busy is done.
            if (busy_q && cur_rdy) begin
               state_d = done_s;
            end else if (tmo) begin
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + 1'b1;
               if (!cur_rdy) busy_d = 1'b1;
            end
         end
         S_ERR: state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_arc4_phase_ctrl.sv
// Bench for arc4_phase_ctrl: three instances (default, short
// watchdog, no PRGA) against a cycle-schedule reference model.
module tb_arc4_phase_ctrl;

   localparam int ND = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [ND-1:0]       rst;
   logic [ND-1:0]       en;
   logic [ND-1:0]       rdy_o;
   logic [ND-1:0]       err_o;
   logic [ND-1:0][1:0]  ph_o;
   logic [ND-1:0][2:0]  cen;
   logic [ND-1:0][2:0]  crdy;
   logic [ND-1:0][7:0]  sa_o;
   logic [ND-1:0][7:0]  sd_o;
   logic [ND-1:0]       sw_o;
   logic [2:0][7:0]     ra;
   logic [2:0][7:0]     rd;
   logic [2:0]          rw;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      arc4_phase_ctrl #(
         .TIMEOUT  (g == 1 ? 16 : 4096),
         .RUN_PRGA (g == 2 ? 1'b0 : 1'b1)
      ) u_dut (
         .clk         (clk),
         .rst         (rst[g]),
         .en          (en[g]),
         .rdy         (rdy_o[g]),
         .err         (err_o[g]),
         .phase       (ph_o[g]),
         .init_en     (cen[g][0]),
         .init_rdy    (crdy[g][0]),
         .ksa_en      (cen[g][1]),
         .ksa_rdy     (crdy[g][1]),
         .prga_en     (cen[g][2]),
         .prga_rdy    (crdy[g][2]),
         .init_addr   (ra[0]),
         .init_wrdata (rd[0]),
         .init_wren   (rw[0]),
         .ksa_addr    (ra[1]),
         .ksa_wrdata  (rd[1]),
         .ksa_wren    (rw[1]),
         .prga_addr   (ra[2]),
         .prga_wrdata (rd[2]),
         .prga_wren   (rw[2]),
         .s_addr      (sa_o[g]),
         .s_wrdata    (sd_o[g]),
         .s_wren      (sw_o[g])
      );
   end

   // Core models: after en, rdy stays high for hold cycles,
   // low for busy cycles, then high again.
   int hold [ND][3];
   int busy [ND][3];
   int tcnt [ND][3];

   always_comb begin
      crdy = '0;
      for (int d = 0; d < ND; d++)
         for (int c = 0; c < 3; c++)
            crdy[d][c] = !(tcnt[d][c] > hold[d][c] + 1 &&
                           tcnt[d][c] <= hold[d][c] + busy[d][c] + 1);
   end

   always @(negedge clk) begin
      for (int d = 0; d < ND; d++)
         for (int c = 0; c < 3; c++) begin
            if (rst[d])
               tcnt[d][c] <= 0;
            else if (cen[d][c])
               tcnt[d][c] <= 1;
            else if (tcnt[d][c] != 0)
               tcnt[d][c] <= (tcnt[d][c] >= hold[d][c] + busy[d][c] + 1)
                             ? 0 : tcnt[d][c] + 1;
         end
   end

   // Reference schedule per instance (cycle numbers)
   int k     [ND];
   int sta   [ND];
   int st    [ND][3];
   int pu    [ND][3];
   int ed    [ND][3];
   int lastc [ND];
   int errc  [ND];
   int rsta  [ND];
   int rmode [ND];
   int cyc;
   int checks;
   int errors;
   bit force_rst;

   function automatic int nph(input int d);
      return (d == 2) ? 2 : 3;
   endfunction

   task automatic plan(input int d, input int kk);
      int s;
      int to;
      to      = (d == 1) ? 16 : 4096;
      k[d]    = kk;
      errc[d] = -1;
      rsta[d] = -1;
      s       = kk + 1;
      for (int p = 0; p < nph(d); p++) begin
         st[d][p] = s;
         pu[d][p] = s + 1;
         ed[d][p] = pu[d][p] + hold[d][p] + busy[d][p] + 1;
         if (errc[d] < 0 && hold[d][p] + busy[d][p] + 1 > to)
            errc[d] = pu[d][p] + 1 + to;
         s = ed[d][p] + 1;
      end
      lastc[d] = ed[d][nph(d)-1];
      if (errc[d] >= 0)
         rsta[d] = errc[d] + 4;
      else if (rmode[d] == 1)
         rsta[d] = pu[d][1] + 1 +
                   int'($urandom_range(0, hold[d][1] + busy[d][1]));
   endtask

   task automatic chk(input string tag, input int d,
                      input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s dut%0d cyc%0d got %0h exp %0h",
                tag, d, cyc, obs, expv);
      end
   endtask

   task automatic check_dut(input int d);
      logic       e_rdy;
      logic       e_err;
      logic [1:0] e_ph;
      logic [2:0] e_en;
      logic [7:0] e_a;
      logic [7:0] e_d;
      logic       e_w;
      bit         act;
      e_rdy = 1'b1;
      e_err = 1'b0;
      e_ph  = 2'd0;
      e_en  = 3'd0;
      e_a   = 8'h00;
      e_d   = 8'h00;
      e_w   = 1'b0;
      act = k[d] >= 0 && cyc > k[d] &&
            !(rsta[d] >= 0 && cyc > rsta[d]);
      if (act && errc[d] >= 0 && cyc >= errc[d]) begin
         e_rdy = 1'b0;
         e_err = 1'b1;
      end else if (act && cyc <= lastc[d]) begin
         e_rdy = 1'b0;
         for (int p = 0; p < nph(d); p++)
            if (cyc >= st[d][p] && cyc <= ed[d][p]) begin
               e_ph    = 2'(p + 1);
               e_en[p] = (cyc == pu[d][p]);
               e_a     = ra[p];
               e_d     = rd[p];
               e_w     = rw[p];
            end
      end
      chk("rdy",      d, 32'(rdy_o[d]), 32'(e_rdy));
      chk("err",      d, 32'(err_o[d]), 32'(e_err));
      chk("phase",    d, 32'(ph_o[d]),  32'(e_ph));
      chk("core_en",  d, 32'(cen[d]),   32'(e_en));
      chk("s_addr",   d, 32'(sa_o[d]),  32'(e_a));
      chk("s_wrdata", d, 32'(sd_o[d]),  32'(e_d));
      chk("s_wren",   d, 32'(sw_o[d]),  32'(e_w));
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      for (int c = 0; c < 3; c++) begin
         ra[c] = 8'($urandom);
         rd[c] = 8'($urandom);
         rw[c] = 1'($urandom);
      end
      for (int d = 0; d < ND; d++) begin
         en[d]  = 1'b0;
         rst[d] = force_rst;
         if (!force_rst) begin
            if (cyc == sta[d]) begin
               en[d] = 1'b1;
               plan(d, cyc);
            end else if (k[d] >= 0 && cyc > k[d]) begin
               if (rsta[d] == cyc)
                  rst[d] = 1'b1;
               else if (errc[d] >= 0 && cyc >= errc[d] && cyc < rsta[d])
                  en[d] = 1'b1;
               else if (cyc <= lastc[d] && (rsta[d] < 0 || cyc < rsta[d]))
                  en[d] = ($urandom_range(0, 5) == 0);
            end
         end
      end
      @(negedge clk);
      for (int d = 0; d < ND; d++) check_dut(d);
   endtask

   function automatic bit run_done();
      int e;
      for (int d = 0; d < ND; d++) begin
         if (k[d] < sta[d]) return 1'b0;
         e = (rsta[d] >= 0) ? rsta[d] + 3 : lastc[d] + 3;
         if (cyc < e) return 1'b0;
      end
      return 1'b1;
   endfunction

   initial begin
      int guard;
      rst       = '1;
      en        = '0;
      ra        = '0;
      rd        = '0;
      rw        = '0;
      force_rst = 1'b1;
      cyc       = 0;
      checks    = 0;
      errors    = 0;
      for (int d = 0; d < ND; d++) begin
         k[d]     = -1;
         sta[d]   = -1;
         lastc[d] = -1;
         errc[d]  = -1;
         rsta[d]  = -1;
         rmode[d] = 0;
         for (int c = 0; c < 3; c++) begin
            hold[d][c] = 0;
            busy[d][c] = 1;
         end
      end
      tick();
      tick();
      force_rst = 1'b0;
      for (int r = 0; r < 5; r++) begin
         for (int d = 0; d < ND; d++)
            for (int c = 0; c < 3; c++) begin
               hold[d][c] = int'($urandom_range(0, 4));
               busy[d][c] = (d == 1) ? int'($urandom_range(1, 20))
                                     : int'($urandom_range(1, 60));
            end
         if (r == 0) begin
            hold[0] = '{0, 0, 0};
            busy[0] = '{256, 768, 64};
            hold[1] = '{0, 0, 0};
            busy[1] = '{10, 1000000, 5};
            hold[2] = '{3, 3, 3};
            busy[2] = '{30, 40, 50};
         end
         for (int d = 0; d < ND; d++) begin
            rmode[d] = (d == 0 && r == 3) ? 1 : 0;
            sta[d]   = cyc + 2 + int'($urandom_range(0, 4));
         end
         guard = 0;
         while (!run_done() && guard < 30000) begin
            tick();
            guard++;
         end
         checks++;
         assert (guard < 30000) else begin
            errors++;
            $error("FAIL run_timeout run%0d got %0d cycles exp <30000",
                   r, guard);
         end
      end
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
